conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 103 ++++++++++
 tb/tb_conv_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
`timescale 1ns/1ps
// Sequencer for a 3x3 convolution engine: walks output windows row-major, TAPS MAC cycles then one writeback each.
// Latency: frame done pulse 361 cycles after start at defaults; stall freezes the sequence in the current cycle.
module conv_seq_ctrl #(
  parameter int OUT_H = 6,
  parameter int OUT_W = 6,
  parameter int TAPS  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic       stall,
  output logic       busy,
  output logic [2:0] r_cnt,
  output logic [2:0] c_cnt,
  output logic [3:0] cnt_3x3,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       wr_en,
  output logic       out_vld
);

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] r_q, r_d;
  logic [2:0] c_q, c_d;
  logic [3:0] t_q, t_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          state_d = MAC;
          r_d     = '0;
          c_d     = '0;
          t_d     = '0;
        end
      end
      MAC: begin
        if (!stall) begin
          if (t_q == 4'(TAPS - 1)) begin
            t_d     = '0;
            state_d = WB;
          end else begin
            t_d = t_q + 4'd1;
          end
        end
      end
      WB: begin
        // Window advance happens on the edge leaving WB so the write sees the window just computed.
        if (!stall) begin
          if (c_q == 3'(OUT_W - 1)) begin
            c_d = '0;
            if (r_q == 3'(OUT_H - 1)) begin
              r_d     = '0;
              state_d = DONE;
            end else begin
              r_d     = r_q + 3'd1;
              state_d = MAC;
            end
          end else begin
            c_d     = c_q + 3'd1;
            state_d = MAC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs forced low while rst is held so an aborted frame issues no write or done pulse.
  always_comb begin
    busy    = !rst && (state_q != IDLE);
    r_cnt   = rst ? 3'd0 : r_q;
    c_cnt   = rst ? 3'd0 : c_q;
    cnt_3x3 = rst ? 4'd0 : t_q;
    acc_en  = !rst && (state_q == MAC) && !stall;
    acc_clr = !rst && (state_q == MAC) && !stall && (t_q == 4'd0);
    wr_en   = !rst && (state_q == WB) && !stall;
    out_vld = !rst && (state_q == DONE);
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for conv_seq_ctrl: full frames with stalls, busy-time start pulses, mid-frame reset.
module tb_conv_seq_ctrl;

  logic       clk, rst, in_vld, stall;
  logic       busy, acc_clr, acc_en, wr_en, out_vld;
  logic [2:0] r_cnt, c_cnt;
  logic [3:0] cnt_3x3;

  int n_asrt = 0;
  int n_fail = 0;

  conv_seq_ctrl #(.OUT_H(6), .OUT_W(6), .TAPS(9)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .stall(stall),
    .busy(busy), .r_cnt(r_cnt), .c_cnt(c_cnt), .cnt_3x3(cnt_3x3),
    .acc_clr(acc_clr), .acc_en(acc_en), .wr_en(wr_en), .out_vld(out_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_r"}, 16'(r_cnt), 16'd0);
    chk({tag, "_c"}, 16'(c_cnt), 16'd0);
    chk({tag, "_t"}, 16'(cnt_3x3), 16'd0);
    chk({tag, "_ctl"}, 16'({acc_clr, acc_en, wr_en, out_vld}), 16'd0);
  endtask

  // One frame started from IDLE. Optional: MAC stall (sr,sc,st,slen), WB stall (wr,wc,wlen),
  // start pulse while busy at tap 0 of (pr,pc), reset at (ar,ac,at), start pulse during DONE (dv).
  task automatic do_frame(input int sr, input int sc, input int st, input int slen,
                          input int wr, input int wc, input int wlen,
                          input int pr, input int pc,
                          input int ar, input int ac, input int at, input bit dv);
    int cyc;
    in_vld = 1'b1;
    #1;
    chk("start_idle_busy", 16'(busy), 16'd0);
    tick();
    in_vld = 1'b0;
    cyc = 1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        for (int t = 0; t < 9; t++) begin
          if (r == ar && c == ac && t == at) begin
            rst = 1'b1;
            #1;
            chk_quiet("rst_hold");
            tick();
            rst = 1'b0;
            #1;
            chk_quiet("rst_after");
            return;
          end
          if (r == sr && c == sc && t == st) begin
            for (int k = 0; k < slen; k++) begin
              stall = 1'b1;
              #1;
              chk("mstall_t", 16'(cnt_3x3), 16'(t));
              chk("mstall_rc", 16'({r_cnt, c_cnt}), 16'({3'(r), 3'(c)}));
              chk("mstall_ctl", 16'({busy, acc_clr, acc_en, wr_en}), 16'b1000);
              tick();
              cyc++;
            end
            stall = 1'b0;
          end
          in_vld = (r == pr && c == pc && t == 0);
          #1;
          chk("mac_t", 16'(cnt_3x3), 16'(t));
          chk("mac_rc", 16'({r_cnt, c_cnt}), 16'({3'(r), 3'(c)}));
          chk("mac_ctl", 16'({busy, acc_clr, acc_en, wr_en, out_vld}),
              16'({1'b1, (t == 0), 1'b1, 1'b0, 1'b0}));
          tick();
          cyc++;
          in_vld = 1'b0;
        end
        if (r == wr && c == wc) begin
          for (int k = 0; k < wlen; k++) begin
            stall = 1'b1;
            #1;
            chk("wstall_rc", 16'({r_cnt, c_cnt}), 16'({3'(r), 3'(c)}));
            chk("wstall_ctl", 16'({busy, acc_clr, acc_en, wr_en}), 16'b1000);
            tick();
            cyc++;
          end
          stall = 1'b0;
        end
        #1;
        chk("wb_rc", 16'({r_cnt, c_cnt}), 16'({3'(r), 3'(c)}));
        chk("wb_ctl", 16'({busy, cnt_3x3, acc_clr, acc_en, wr_en, out_vld}), 16'b1_0000_0010);
        tick();
        cyc++;
      end
    end
    // DONE ignores stall; hold it high here to show that.
    stall  = 1'b1;
    in_vld = dv;
    #1;
    chk("done_ctl", 16'({busy, acc_clr, acc_en, wr_en, out_vld}), 16'b10001);
    chk("done_rc", 16'({r_cnt, c_cnt}), 16'd0);
    chk("latency", 16'(cyc), 16'(361 + slen + wlen));
    tick();
    stall  = 1'b0;
    in_vld = 1'b0;
    #1;
    chk_quiet("after_done");
  endtask

  initial begin
    rst    = 1'b1;
    in_vld = 1'b1;
    stall  = 1'b0;
    #1;
    chk_quiet("in_reset");
    tick();
    tick();
    chk_quiet("rst_prio");
    rst    = 1'b0;
    in_vld = 1'b0;
    tick();
    chk_quiet("idle_no_req");

    // plain frame
    do_frame(-1, -1, -1, 0, -1, -1, 0, -1, -1, -1, -1, -1, 1'b0);
    // 5-cycle stall at tap 4 of (2,3)
    do_frame(2, 3, 4, 5, -1, -1, 0, -1, -1, -1, -1, -1, 1'b0);
    // 3-cycle stall in WB of (0,5)
    do_frame(-1, -1, -1, 0, 0, 5, 3, -1, -1, -1, -1, -1, 1'b0);
    // start pulse while busy at (3,3)
    do_frame(-1, -1, -1, 0, -1, -1, 0, 3, 3, -1, -1, -1, 1'b0);
    // reset at (4,1) tap 6, then restart
    do_frame(-1, -1, -1, 0, -1, -1, 0, -1, -1, 4, 1, 6, 1'b0);
    // start pulse coincident with out_vld is dropped
    do_frame(-1, -1, -1, 0, -1, -1, 0, -1, -1, -1, -1, -1, 1'b1);
    // a start on the following IDLE cycle runs normally
    do_frame(-1, -1, -1, 0, -1, -1, 0, -1, -1, -1, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
